// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional even-parity framing is selected by defining UART_PROG_LOADER_PARITY_EN.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_t;

    localparam logic [15:0] MIN_CLK_PER_BIT    = 16'd4;
    localparam logic [31:0] END_MARKER_DEFAULT = 32'h0000_0FFF;

    // Very short bit periods leave no room for a mid-bit sample point.
    function automatic logic [15:0] clamp_clk_per_bit(input logic [15:0] n);
        return (n < MIN_CLK_PER_BIT) ? MIN_CLK_PER_BIT : n;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface uart_prog_loader_if #(
    parameter int ADDR_W = 13
);
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;

    modport master (output mem_we_o, mem_addr_o, mem_wdata_o);
    modport slave  (input  mem_we_o, mem_addr_o, mem_wdata_o);
endinterface

// File: rtl/uart_prog_loader_rx_core.sv
// UART receiver: 2-flop synchronizer, bit-timing FSM and byte strobe.
// Even-parity (8E1) framing when UART_PROG_LOADER_PARITY_EN is defined, 8N1 otherwise.
module uart_rx_core
    import uart_prog_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_rx,
    input  logic [15:0] i_clk_per_bit,
    input  logic        i_halt,
    output logic        o_byte_vld,
    output logic [7:0]  o_byte,
`ifdef UART_PROG_LOADER_PARITY_EN
    output logic        o_parity_err,
`endif
    output logic        o_frame_err
);

    logic        r_sync1, r_sync2, r_sync3;
    rx_state_t   r_state, w_next;
    logic [15:0] r_cnt, r_n;
    logic [2:0]  r_bits;
    logic [7:0]  r_shift;
    logic        r_byte_vld, r_frame_err;
    logic        w_fall, w_tick;
`ifdef UART_PROG_LOADER_PARITY_EN
    logic        r_par_bad, r_parity_err;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall = r_sync3 & ~r_sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_halt) begin
            w_next = DONE;
        end else begin
            case (r_state)
                IDLE:   if (w_fall) w_next = START;
                START:  if (w_tick) w_next = r_sync2 ? IDLE : DATA;
`ifdef UART_PROG_LOADER_PARITY_EN
                DATA:   if (w_tick && r_bits == 3'd7) w_next = PARITY;
`else
                DATA:   if (w_tick && r_bits == 3'd7) w_next = STOP;
`endif
                PARITY: if (w_tick) w_next = STOP;
                STOP:   if (w_tick) w_next = IDLE;
                DONE:   w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Sample strobe: half a bit into the start bit, then once per full bit.
    always_comb begin
        w_tick = 1'b0;
        case (r_state)
            START:              w_tick = (r_cnt == (r_n >> 1) - 16'd1);
            DATA, PARITY, STOP: w_tick = (r_cnt == r_n - 16'd1);
            default:            w_tick = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 16'd0;
            r_n         <= MIN_CLK_PER_BIT;
            r_bits      <= 3'd0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_parity_err <= 1'b0;
            if (r_state == PARITY && w_tick) r_par_bad <= (r_sync2 != ^r_shift);
`endif
            if (r_state == IDLE || r_state == DONE) begin
                r_cnt  <= 16'd0;
                r_bits <= 3'd0;
`ifdef UART_PROG_LOADER_PARITY_EN
                r_par_bad <= 1'b0;
`endif
                // Bit period is frozen for the whole frame at the start edge.
                if (r_state == IDLE && w_fall) r_n <= clamp_clk_per_bit(i_clk_per_bit);
            end else if (w_tick) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == DATA && w_tick) r_bits <= r_bits + 3'd1;
            if (r_state == STOP && w_tick) begin
                if (!r_sync2) r_frame_err <= 1'b1;
`ifdef UART_PROG_LOADER_PARITY_EN
                else if (r_par_bad) r_parity_err <= 1'b1;
`endif
                else r_byte_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (r_state == DATA && w_tick) r_shift <= {r_sync2, r_shift[7:1]};
    end

    assign o_byte_vld  = r_byte_vld;
    assign o_byte      = r_shift;
    assign o_frame_err = r_frame_err;
`ifdef UART_PROG_LOADER_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: UART bytes -> little-endian words -> sequential instruction-memory writes.
// Define UART_PROG_LOADER_PARITY_EN for 8E1 framing and the parity_err_o status port.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int          ADDR_W     = 13,
    parameter logic [31:0] END_MARKER = END_MARKER_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx_i,
    input  logic [15:0]         clk_per_bit_i,
    uart_prog_loader_if.master  mem_if,
    output logic                core_rst_o,
    output logic                prog_done_o,
    output logic                frame_err_o,
`ifdef UART_PROG_LOADER_PARITY_EN
    output logic                parity_err_o,
`endif
    output logic                addr_ovf_o
);

    logic              w_byte_vld, w_frame_err, w_commit;
    logic [7:0]        w_byte;
    logic [31:0]       w_full;
    logic [1:0]        r_lane;
    logic [23:0]       r_word;
    logic [ADDR_W-1:0] r_next, r_addr;
    logic [31:0]       r_wdata;
    logic              r_we, r_core_rst, r_done, r_ferr, r_ovf;
`ifdef UART_PROG_LOADER_PARITY_EN
    logic              w_parity_err, r_perr;
`endif

    uart_rx_core u_rx (
        .clock         (clock),
        .reset         (reset),
        .i_rx          (rx_i),
        .i_clk_per_bit (clk_per_bit_i),
        .i_halt        (r_done),
        .o_byte_vld    (w_byte_vld),
        .o_byte        (w_byte),
`ifdef UART_PROG_LOADER_PARITY_EN
        .o_parity_err  (w_parity_err),
`endif
        .o_frame_err   (w_frame_err)
    );

    assign w_full   = {w_byte, r_word};
    assign w_commit = w_byte_vld && (r_lane == 2'd3);

    // Lanes 0..2 are buffered; lane 3 goes straight into the committed word.
    always_ff @(posedge clock) begin
        if (w_byte_vld) begin
            case (r_lane)
                2'd0:    r_word[7:0]   <= w_byte;
                2'd1:    r_word[15:8]  <= w_byte;
                2'd2:    r_word[23:16] <= w_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lane     <= 2'd0;
            r_next     <= '0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_we       <= 1'b0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovf      <= 1'b0;
`ifdef UART_PROG_LOADER_PARITY_EN
            r_perr     <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_byte_vld) r_lane <= r_lane + 2'd1;
            if (w_commit) begin
                if (w_full == END_MARKER) begin
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_next;
                    r_wdata <= w_full;
                    r_next  <= r_next + ADDR_W'(1);
                    if (&r_next) r_ovf <= 1'b1;
                end
            end
            if (w_frame_err) r_ferr <= 1'b1;
`ifdef UART_PROG_LOADER_PARITY_EN
            if (w_parity_err) r_perr <= 1'b1;
`endif
        end
    end

    assign mem_if.mem_we_o    = r_we;
    assign mem_if.mem_addr_o  = r_addr;
    assign mem_if.mem_wdata_o = r_wdata;
    assign core_rst_o         = r_core_rst;
    assign prog_done_o        = r_done;
    assign frame_err_o        = r_ferr;
    assign addr_ovf_o         = r_ovf;
`ifdef UART_PROG_LOADER_PARITY_EN
    assign parity_err_o       = r_perr;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a write scoreboard; small ADDR_W exercises wrap.
module tb_uart_prog_loader;

    localparam int AW = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_i  = 1'b1;
    logic [15:0] clk_per_bit_i = 16'd16;
    logic        core_rst_o, prog_done_o, frame_err_o, addr_ovf_o;
`ifdef UART_PROG_LOADER_PARITY_EN
    logic        parity_err_o;
`endif

    uart_prog_loader_if #(.ADDR_W(AW)) mem_if ();

    uart_prog_loader #(.ADDR_W(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx_i          (rx_i),
        .clk_per_bit_i (clk_per_bit_i),
        .mem_if        (mem_if),
        .core_rst_o    (core_rst_o),
        .prog_done_o   (prog_done_o),
        .frame_err_o   (frame_err_o),
`ifdef UART_PROG_LOADER_PARITY_EN
        .parity_err_o  (parity_err_o),
`endif
        .addr_ovf_o    (addr_ovf_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           sb[$];
    int            total = 0;
    int            bad = 0;
    int            n_writes = 0;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (mem_if.mem_we_o === 1'b1) begin
            n_writes++;
            check("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_if.mem_addr_o), 32'(e.addr));
                check("wr_data", mem_if.mem_wdata_o, e.data);
            end
        end
    end

    task automatic push_exp(input logic [31:0] w);
        wr_t e;
        e.addr = exp_addr;
        e.data = w;
        sb.push_back(e);
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic bit_time(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int n, input logic stop);
        bit_time(1'b0, n);
        for (int i = 0; i < 8; i++) bit_time(b[i], n);
`ifdef UART_PROG_LOADER_PARITY_EN
        bit_time(^b, n);
`endif
        bit_time(stop, n);
        if (!stop) bit_time(1'b1, 2 * n);
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input bit expect_wr);
        if (expect_wr) push_exp(w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], n, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_we"},       32'(mem_if.mem_we_o),    32'd0);
        check({pfx, "_addr"},     32'(mem_if.mem_addr_o),  32'd0);
        check({pfx, "_wdata"},    mem_if.mem_wdata_o,      32'd0);
        check({pfx, "_core_rst"}, 32'(core_rst_o),         32'd1);
        check({pfx, "_done"},     32'(prog_done_o),        32'd0);
        check({pfx, "_ferr"},     32'(frame_err_o),        32'd0);
        check({pfx, "_ovf"},      32'(addr_ovf_o),         32'd0);
`ifdef UART_PROG_LOADER_PARITY_EN
        check({pfx, "_perr"},     32'(parity_err_o),       32'd0);
`endif
    endtask

    initial begin
        int n_before;
        bit seen;

        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Basic word at N=16
        send_word(32'h0010_0513, 16, 1'b1);
        wait_drain();
        check("t1_core_rst", 32'(core_rst_o), 32'd1);
        check("t1_nwrites", 32'(n_writes), 32'd1);

        // 3-cycle glitch is rejected at the start-bit sample
        bit_time(1'b0, 3);
        bit_time(1'b1, 40);
        check("glitch_ferr", 32'(frame_err_o), 32'd0);
        check("glitch_nwrites", 32'(n_writes), 32'd1);

        // Framing error on the third byte; lane position is preserved
        push_exp(32'h4433_2211);
        send_byte(8'h11, 16, 1'b1);
        send_byte(8'h22, 16, 1'b1);
        send_byte(8'h99, 16, 1'b0);
        check("ferr_set", 32'(frame_err_o), 32'd1);
        check("ferr_nowrite", 32'(n_writes), 32'd1);
        send_byte(8'h33, 16, 1'b1);
        send_byte(8'h44, 16, 1'b1);
        wait_drain();
        check("ferr_nwrites", 32'(n_writes), 32'd2);

        // Clamp: programmed 2 behaves as 4 cycles/bit
        clk_per_bit_i = 16'd2;
        send_word(32'h3C5A_96A5, 4, 1'b1);
        wait_drain();

        // Fill to the top address and wrap
        for (int k = 3; k < 7; k++) begin
            send_word(32'hC0DE_0000 + 32'(k), 4, 1'b1);
            wait_drain();
        end
        check("ovf_before_wrap", 32'(addr_ovf_o), 32'd0);
        send_word(32'hC0DE_0007, 4, 1'b1);
        wait_drain();
        check("ovf_after_top", 32'(addr_ovf_o), 32'd1);
        send_word(32'hBEEF_0000, 4, 1'b1);
        wait_drain();
        check("wrap_nwrites", 32'(n_writes), 32'd9);

        // Reset mid-word discards the partial word
        clk_per_bit_i = 16'd16;
        send_byte(8'hDE, 16, 1'b1);
        send_byte(8'hAD, 16, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clock);
        reset = 1'b1;
        exp_addr = '0;
        repeat (4) @(negedge clock);
        send_word(32'h1234_5678, 16, 1'b1);
        wait_drain();
        send_word(32'h0BAD_F00D, 16, 1'b1);
        wait_drain();
        check("pre_end_core_rst", 32'(core_rst_o), 32'd1);

        // End marker: no write, done and core release together
        n_before = n_writes;
        send_word(32'h0000_0FFF, 16, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (prog_done_o === 1'b1) seen = 1'b1;
            else @(negedge clock);
        end
        check("end_done", 32'(prog_done_o), 32'd1);
        check("end_core_rst", 32'(core_rst_o), 32'd0);
        check("end_nowrite", 32'(n_writes), 32'(n_before));

        // Traffic after DONE is ignored
        send_word(32'h1111_1111, 16, 1'b0);
        repeat (50) @(negedge clock);
        check("post_done_nowrite", 32'(n_writes), 32'(n_before));
        check("post_done_sticky", 32'(prog_done_o), 32'd1);
        check("post_done_sb", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
